// File: rtl/mastermind_engine.sv
// ----------------------------------------------------------------------------
// mastermind_engine
//   Game core: latches the secret code, accepts guesses, scores each guess
//   (exact hits in one cycle, then one cycle per colour for the colour-count
//   pass), keeps a guess/score history and tracks turns, win and game over.
//
//   Optional feature macro: MM_DUP_REJECT_EN
//     defined   : a guess equal to a stored history entry is rejected one
//                 cycle after accept (fb_valid + fb_reject, no turn consumed)
//     undefined : duplicates are scored normally, fb_reject stays 0
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   code_load, code_in      1-cycle pulse to latch a new code and restart
//   guess_valid, guess_in   guess offer (taken when guess_ready is high)
//   guess_ready             core is in PLAY and can take a guess
//   fb_valid                1-cycle pulse, fb_exact/fb_partial/fb_reject valid
//   fb_exact, fb_partial    exact hits, colour-only hits
//   fb_reject               duplicate guess rejected
//   turn                    guesses scored this game (saturates at MAX_TURNS)
//   game_over, win          end-of-game flags
//   hist_sel                history read index (0 = first guess)
//   hist_guess/exact/partial  combinational history read, zero beyond turn
// ----------------------------------------------------------------------------
module mastermind_engine #(
    parameter int NUM_PEGS  = 4,
    parameter int COLOR_W   = 3,
    parameter int MAX_TURNS = 8
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 code_load,
    input  logic [NUM_PEGS*COLOR_W-1:0]          code_in,
    input  logic                                 guess_valid,
    input  logic [NUM_PEGS*COLOR_W-1:0]          guess_in,
    output logic                                 guess_ready,
    output logic                                 fb_valid,
    output logic [$clog2(NUM_PEGS+1)-1:0]        fb_exact,
    output logic [$clog2(NUM_PEGS+1)-1:0]        fb_partial,
    output logic                                 fb_reject,
    output logic [$clog2(MAX_TURNS+1)-1:0]       turn,
    output logic                                 game_over,
    output logic                                 win,
    input  logic [$clog2(MAX_TURNS)-1:0]         hist_sel,
    output logic [NUM_PEGS*COLOR_W-1:0]          hist_guess,
    output logic [$clog2(NUM_PEGS+1)-1:0]        hist_exact,
    output logic [$clog2(NUM_PEGS+1)-1:0]        hist_partial
);

    localparam int CODE_W = NUM_PEGS * COLOR_W;
    localparam int CNT_W  = $clog2(NUM_PEGS + 1);
    localparam int TURN_W = $clog2(MAX_TURNS + 1);
    localparam int SEL_W  = $clog2(MAX_TURNS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PLAY   = 3'd1,
        S_EXACT  = 3'd2,
        S_COLOR  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t               state_r;
    logic [CODE_W-1:0]    code_r;
    logic [CODE_W-1:0]    guess_r;
    logic [CNT_W-1:0]     exact_r;
    logic [CNT_W-1:0]     acc_r;
    logic [COLOR_W-1:0]   color_r;
    logic [CODE_W-1:0]    hist_guess_r   [MAX_TURNS];
    logic [CNT_W-1:0]     hist_exact_r   [MAX_TURNS];
    logic [CNT_W-1:0]     hist_partial_r [MAX_TURNS];

    logic [CNT_W-1:0]     exact_s;
    logic [CNT_W-1:0]     code_cnt_s;
    logic [CNT_W-1:0]     guess_cnt_s;
    logic [CNT_W-1:0]     min_s;
    logic                 dup_s;

    // Per-peg equality count and occurrences of the colour under test in code/guess
    always_comb begin
        exact_s     = '0;
        code_cnt_s  = '0;
        guess_cnt_s = '0;
        for (int i = 0; i < NUM_PEGS; i++) begin
            if (code_r[i*COLOR_W +: COLOR_W] == guess_r[i*COLOR_W +: COLOR_W]) begin
                exact_s = exact_s + CNT_W'(1);
            end else begin
                exact_s = exact_s;
            end
            if (code_r[i*COLOR_W +: COLOR_W] == color_r) begin
                code_cnt_s = code_cnt_s + CNT_W'(1);
            end else begin
                code_cnt_s = code_cnt_s;
            end
            if (guess_r[i*COLOR_W +: COLOR_W] == color_r) begin
                guess_cnt_s = guess_cnt_s + CNT_W'(1);
            end else begin
                guess_cnt_s = guess_cnt_s;
            end
        end
        min_s = guess_cnt_s;
        if (code_cnt_s < guess_cnt_s) begin
            min_s = code_cnt_s;
        end else begin
            min_s = guess_cnt_s;
        end
    end

`ifdef MM_DUP_REJECT_EN
    // Parallel compare of the registered guess against every valid history entry
    always_comb begin
        dup_s = 1'b0;
        for (int j = 0; j < MAX_TURNS; j++) begin
            if ((TURN_W'(j) < turn) && (hist_guess_r[j] == guess_r)) begin
                dup_s = 1'b1;
            end else begin
                dup_s = dup_s;
            end
        end
    end
`else
    assign dup_s = 1'b0;
`endif

    // History read port; entries not yet written this game read as zero
    always_comb begin
        hist_guess   = '0;
        hist_exact   = '0;
        hist_partial = '0;
        if (TURN_W'(hist_sel) < turn) begin
            hist_guess   = hist_guess_r[hist_sel];
            hist_exact   = hist_exact_r[hist_sel];
            hist_partial = hist_partial_r[hist_sel];
        end else begin
            hist_guess   = '0;
            hist_exact   = '0;
            hist_partial = '0;
        end
    end

    // Game FSM with all registered outputs; code_load overrides any state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= S_IDLE;
            code_r      <= '0;
            guess_r     <= '0;
            exact_r     <= '0;
            acc_r       <= '0;
            color_r     <= '0;
            guess_ready <= 1'b0;
            fb_valid    <= 1'b0;
            fb_exact    <= '0;
            fb_partial  <= '0;
            fb_reject   <= 1'b0;
            turn        <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            for (int k = 0; k < MAX_TURNS; k++) begin
                hist_guess_r[k]   <= '0;
                hist_exact_r[k]   <= '0;
                hist_partial_r[k] <= '0;
            end
        end else if (code_load) begin
            state_r     <= S_PLAY;
            code_r      <= code_in;
            guess_ready <= 1'b1;
            fb_valid    <= 1'b0;
            fb_exact    <= '0;
            fb_partial  <= '0;
            fb_reject   <= 1'b0;
            turn        <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            for (int k = 0; k < MAX_TURNS; k++) begin
                hist_guess_r[k]   <= '0;
                hist_exact_r[k]   <= '0;
                hist_partial_r[k] <= '0;
            end
        end else begin
            fb_valid <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    state_r <= S_IDLE;
                end
                S_PLAY: begin
                    if (guess_valid && guess_ready) begin
                        guess_r     <= guess_in;
                        guess_ready <= 1'b0;
                        state_r     <= S_EXACT;
                    end else begin
                        state_r <= S_PLAY;
                    end
                end
                S_EXACT: begin
                    if (dup_s) begin
                        fb_valid    <= 1'b1;
                        fb_reject   <= 1'b1;
                        guess_ready <= 1'b1;
                        state_r     <= S_PLAY;
                    end else begin
                        exact_r <= exact_s;
                        acc_r   <= '0;
                        color_r <= '0;
                        state_r <= S_COLOR;
                    end
                end
                S_COLOR: begin
                    acc_r <= acc_r + min_s;
                    if (color_r == {COLOR_W{1'b1}}) begin
                        state_r <= S_REPORT;
                    end else begin
                        color_r <= color_r + COLOR_W'(1);
                    end
                end
                S_REPORT: begin
                    fb_valid   <= 1'b1;
                    fb_reject  <= 1'b0;
                    fb_exact   <= exact_r;
                    // acc counts every colour match, so it always covers the exact hits
                    fb_partial <= acc_r - exact_r;
                    if (turn < TURN_W'(MAX_TURNS)) begin
                        hist_guess_r[SEL_W'(turn)]   <= guess_r;
                        hist_exact_r[SEL_W'(turn)]   <= exact_r;
                        hist_partial_r[SEL_W'(turn)] <= acc_r - exact_r;
                        turn                         <= turn + TURN_W'(1);
                    end else begin
                        turn <= turn;
                    end
                    if (exact_r == CNT_W'(NUM_PEGS)) begin
                        win       <= 1'b1;
                        game_over <= 1'b1;
                        state_r   <= S_DONE;
                    end else if (turn + TURN_W'(1) >= TURN_W'(MAX_TURNS)) begin
                        win       <= 1'b0;
                        game_over <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        guess_ready <= 1'b1;
                        state_r     <= S_PLAY;
                    end
                end
                S_DONE: begin
                    state_r <= S_DONE;
                end
                default: begin
                    state_r     <= S_IDLE;
                    guess_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mastermind_engine.sv
// ----------------------------------------------------------------------------
// tb_mastermind_engine
//   Scoreboard bench for mastermind_engine at default parameters. Each
//   accepted guess pushes its predicted feedback (scores, turn, flags and
//   arrival cycle) to a queue; a negedge monitor pops and compares on fb_valid.
// ----------------------------------------------------------------------------
module tb_mastermind_engine;

    localparam int NP = 4;
    localparam int CW = 3;

    typedef struct {
        int ex;
        int pa;
        int rej;
        int trn;
        int wn;
        int go;
        int cyc;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        code_load;
    logic [11:0] code_in;
    logic        guess_valid;
    logic [11:0] guess_in;
    logic        guess_ready;
    logic        fb_valid;
    logic [2:0]  fb_exact;
    logic [2:0]  fb_partial;
    logic        fb_reject;
    logic [3:0]  turn;
    logic        game_over;
    logic        win;
    logic [2:0]  hist_sel;
    logic [11:0] hist_guess;
    logic [2:0]  hist_exact;
    logic [2:0]  hist_partial;

    int   n_checks;
    int   n_errors;
    int   cyc;
    exp_t sb[$];
    logic [11:0] m_hist[$];
    int   m_turn, m_win, m_go, m_ex, m_pa;

    mastermind_engine dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .code_load    (code_load),
        .code_in      (code_in),
        .guess_valid  (guess_valid),
        .guess_in     (guess_in),
        .guess_ready  (guess_ready),
        .fb_valid     (fb_valid),
        .fb_exact     (fb_exact),
        .fb_partial   (fb_partial),
        .fb_reject    (fb_reject),
        .turn         (turn),
        .game_over    (game_over),
        .win          (win),
        .hist_sel     (hist_sel),
        .hist_guess   (hist_guess),
        .hist_exact   (hist_exact),
        .hist_partial (hist_partial)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle counter used to time-stamp accepts and feedback arrival
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [11:0] pack(input int p0, input int p1, input int p2, input int p3);
        logic [11:0] v;
        v = {3'(p3), 3'(p2), 3'(p1), 3'(p0)};
        return v;
    endfunction

    // Reference scoring by greedy pairing of unmatched pegs
    task automatic score(input logic [11:0] c, input logic [11:0] g, output int ex, output int pa);
        bit cu[NP];
        bit gu[NP];
        ex = 0;
        pa = 0;
        for (int i = 0; i < NP; i++) begin
            cu[i] = 1'b0;
            gu[i] = 1'b0;
        end
        for (int i = 0; i < NP; i++) begin
            if (c[i*CW +: CW] == g[i*CW +: CW]) begin
                ex++;
                cu[i] = 1'b1;
                gu[i] = 1'b1;
            end
        end
        for (int i = 0; i < NP; i++) begin
            if (!gu[i]) begin
                for (int j = 0; j < NP; j++) begin
                    if (!gu[i] && !cu[j] && (g[i*CW +: CW] == c[j*CW +: CW])) begin
                        pa++;
                        cu[j] = 1'b1;
                        gu[i] = 1'b1;
                    end
                end
            end
        end
    endtask

    logic [11:0] m_code;

    task automatic model_clear();
        m_turn = 0;
        m_win  = 0;
        m_go   = 0;
        m_ex   = 0;
        m_pa   = 0;
        m_hist.delete();
        sb.delete();
    endtask

    // Feedback monitor: every fb_valid must match the head of the scoreboard
    always @(negedge clk) begin
        if (reset_n && fb_valid) begin
            if (sb.size() == 0) begin
                check_eq("fb_spurious", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("fb_latency", cyc, e.cyc);
                check_eq("fb_exact", int'(fb_exact), e.ex);
                check_eq("fb_partial", int'(fb_partial), e.pa);
                check_eq("fb_reject", int'(fb_reject), e.rej);
                check_eq("turn", int'(turn), e.trn);
                check_eq("win", int'(win), e.wn);
                check_eq("game_over", int'(game_over), e.go);
            end
        end
    end

    task automatic load_code(input logic [11:0] c);
        @(negedge clk);
        code_load = 1'b1;
        code_in   = c;
        m_code    = c;
        model_clear();
        @(negedge clk);
        code_load = 1'b0;
        check_eq("rdy_after_load", int'(guess_ready), 1);
        check_eq("turn_after_load", int'(turn), 0);
        check_eq("go_after_load", int'(game_over), 0);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check_eq("fb_timeout", sb.size(), 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic send_guess(input logic [11:0] g, input bit wait_done);
        exp_t e;
        int   ex, pa, n;
        bit   dup;
        n = 0;
        @(negedge clk);
        while (!guess_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!guess_ready) begin
            check_eq("rdy_timeout", 0, 1);
            return;
        end
        guess_valid = 1'b1;
        guess_in    = g;
        @(posedge clk);
        #1;
        dup = 1'b0;
`ifdef MM_DUP_REJECT_EN
        foreach (m_hist[k]) begin
            if (m_hist[k] == g) dup = 1'b1;
        end
`endif
        if (dup) begin
            e.cyc = cyc + 1;
            e.rej = 1;
        end else begin
            score(m_code, g, ex, pa);
            m_ex = ex;
            m_pa = pa;
            m_turn++;
            m_hist.push_back(g);
            if (ex == NP) begin
                m_win = 1;
                m_go  = 1;
            end else if (m_turn == 8) begin
                m_go = 1;
            end
            e.cyc = cyc + 10;
            e.rej = 0;
        end
        e.ex  = m_ex;
        e.pa  = m_pa;
        e.trn = m_turn;
        e.wn  = m_win;
        e.go  = m_go;
        sb.push_back(e);
        check_eq("rdy_drop", int'(guess_ready), 0);
        @(negedge clk);
        guess_valid = 1'b0;
        if (wait_done) wait_drain();
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        cyc         = 0;
        reset_n     = 1'b0;
        code_load   = 1'b0;
        code_in     = '0;
        guess_valid = 1'b0;
        guess_in    = '0;
        hist_sel    = '0;
        m_code      = '0;
        model_clear();

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_ready", int'(guess_ready), 0);
        check_eq("rst_fb_valid", int'(fb_valid), 0);
        check_eq("rst_turn", int'(turn), 0);
        check_eq("rst_win", int'(win), 0);
        check_eq("rst_hist", int'(hist_guess), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("idle_ready", int'(guess_ready), 0);

        // 1: all colours right, all positions wrong
        load_code(pack(1, 2, 3, 4));
        send_guess(pack(4, 3, 2, 1), 1'b1);
        check_eq("t1_turn", int'(turn), 1);

        // 2: repeated colours, then history read-back
        load_code(pack(1, 1, 2, 2));
        send_guess(pack(1, 2, 1, 5), 1'b1);
        hist_sel = 3'd0;
        #1;
        check_eq("hist0_guess", int'(hist_guess), int'(pack(1, 2, 1, 5)));
        check_eq("hist0_exact", int'(hist_exact), 1);
        check_eq("hist0_partial", int'(hist_partial), 2);
        hist_sel = 3'd1;
        #1;
        check_eq("hist1_zero", int'(hist_guess), 0);
        hist_sel = 3'd0;

        // 3: win on first guess; further offers ignored
        load_code(pack(5, 6, 7, 0));
        send_guess(pack(5, 6, 7, 0), 1'b1);
        guess_valid = 1'b1;
        guess_in    = pack(1, 1, 1, 1);
        repeat (3) begin
            @(negedge clk);
            check_eq("win_ready_low", int'(guess_ready), 0);
        end
        guess_valid = 1'b0;
        check_eq("t3_win", int'(win), 1);

        // 4: exhaust all turns, then restart
        load_code(pack(1, 2, 3, 4));
        for (int i = 0; i < 8; i++) begin
            send_guess(pack(0, 0, 0, 0), 1'b1);
        end
        guess_valid = 1'b1;
        repeat (3) @(negedge clk);
        guess_valid = 1'b0;
        repeat (12) @(negedge clk);
        check_eq("t4_turn", int'(turn), m_turn);
        check_eq("t4_go", int'(game_over), m_go);
        check_eq("t4_win", int'(win), 0);
        load_code(pack(2, 2, 2, 2));
        check_eq("t4_hist_clear", int'(hist_guess), 0);
        check_eq("t4_hist_exact", int'(hist_exact), 0);

        // 5a: reset in the middle of a scoring pass
        send_guess(pack(4, 3, 2, 1), 1'b0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        #1;
        check_eq("midrst_fb_valid", int'(fb_valid), 0);
        check_eq("midrst_turn", int'(turn), 0);
        check_eq("midrst_ready", int'(guess_ready), 0);
        check_eq("midrst_exact", int'(fb_exact), 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        check_eq("midrst_idle", int'(guess_ready), 0);

        // 5b: code_load in the middle of a scoring pass
        load_code(pack(1, 2, 3, 4));
        send_guess(pack(4, 3, 2, 1), 1'b0);
        repeat (3) @(negedge clk);
        load_code(pack(3, 3, 3, 3));
        repeat (15) @(negedge clk);
        check_eq("midload_turn", int'(turn), 0);

        // 6: repeated guess (rejected with the macro, scored without)
        load_code(pack(7, 7, 7, 7));
        send_guess(pack(0, 1, 2, 3), 1'b1);
        send_guess(pack(0, 1, 2, 3), 1'b1);
        check_eq("t6_turn", int'(turn), m_turn);
        send_guess(pack(7, 1, 7, 3), 1'b1);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
